// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder that steps one operand bit pair
// per clock, LSB first, through a single 1-bit full-adder cell.
// Latency: done pulses WIDTH+1 cycles after an accepted start; start is ignored while busy.

// sa_full_adder: combinational 1-bit full adder (sum and carry-out).
// Latency: zero cycles, purely combinational.
// Backpressure: none; outputs follow inputs continuously.
module sa_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  // Counter is sized to hold WIDTH so it never wraps inside one operation.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CW-1:0]    count;

  logic fa_s;
  logic fa_cout;
  logic accept;
  logic last;

  // The one full-adder cell shared by every bit position.
  sa_full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // A start is honoured in IDLE and in DONE (the latter gives back-to-back ops).
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (state == SHIFT) && (count == LAST_CNT);

  // Sum bits enter at the MSB and walk down, so bit 0 lands at S[0] after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_nxt = fa_s;
    end else begin : g_res_wn
      assign res_nxt = {fa_s, res_sh[WIDTH-1:1]};
    end
  endgenerate

  // Status outputs are decoded straight from the state register.
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters, carry flop, bit counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
      S      <= '0;
      Cout   <= 1'b0;
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= B;
      carry  <= Cin;
      count  <= '0;
      res_sh <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= fa_cout;
      res_sh <= res_nxt;
      count  <= count + CW'(1);
      // Published result only changes here, so S/Cout hold through the next operation.
      if (last) begin
        S    <= res_nxt;
        Cout <= fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and reference-checked tests of the serial adder
// at WIDTH=8 (main), WIDTH=1 and WIDTH=13.
// Inputs change 1 time unit after the rising edge; outputs are read at the same point.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, s8;
  logic        start1, cin1, busy1, done1, cout1;
  logic [0:0]  a1, b1, s1;
  logic        start13, cin13, busy13, done13, cout13;
  logic [12:0] a13, b13, s13;

  int errors = 0;
  int checks = 0;

  // Bench-side record of the last published result for each instance.
  logic [8:0]  res8;
  logic [1:0]  res1;
  logic [13:0] res13;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
    .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Cin(cin1),
    .busy(busy1), .done(done1), .S(s1), .Cout(cout1)
  );

  serial_adder_ctrl #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .A(a13), .B(b13), .Cin(cin13),
    .busy(busy13), .done(done13), .S(s13), .Cout(cout13)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation; returns in the done cycle so callers can chain a start.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input string tag);
    logic [8:0] e;
    e = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~ci;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0 || {cout8, s8} !== res8) begin
        errors++;
        $display("FAIL %s shift cycle %0d: busy=%b done=%b {Cout,S}=%h, required busy=1 done=0 {Cout,S}=%h",
                 tag, c, busy8, done8, {cout8, s8}, res8);
      end
      step();
    end
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || {cout8, s8} !== e) begin
      errors++;
      $display("FAIL %s done cycle: busy=%b done=%b {Cout,S}=%h, required busy=0 done=1 {Cout,S}=%h",
               tag, busy8, done8, {cout8, s8}, e);
    end
    res8 = e;
  endtask

  task automatic op1(input logic a, input logic b, input logic ci, input string tag);
    logic [1:0] e;
    e = {1'b0, a} + {1'b0, b} + {1'b0, ci};
    a1 = a; b1 = b; cin1 = ci; start1 = 1'b1;
    step();
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0 || {cout1, s1} !== res1) begin
      errors++;
      $display("FAIL %s shift cycle 1: busy=%b done=%b {Cout,S}=%b, required busy=1 done=0 {Cout,S}=%b",
               tag, busy1, done1, {cout1, s1}, res1);
    end
    step();
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || {cout1, s1} !== e) begin
      errors++;
      $display("FAIL %s done cycle 2: busy=%b done=%b {Cout,S}=%b, required busy=0 done=1 {Cout,S}=%b",
               tag, busy1, done1, {cout1, s1}, e);
    end
    res1 = e;
  endtask

  task automatic op13(input logic [12:0] a, input logic [12:0] b, input logic ci, input string tag);
    logic [13:0] e;
    e = {1'b0, a} + {1'b0, b} + {13'd0, ci};
    a13 = a; b13 = b; cin13 = ci; start13 = 1'b1;
    step();
    start13 = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      checks++;
      if (busy13 !== 1'b1 || done13 !== 1'b0 || {cout13, s13} !== res13) begin
        errors++;
        $display("FAIL %s shift cycle %0d: busy=%b done=%b {Cout,S}=%h, required busy=1 done=0 {Cout,S}=%h",
                 tag, c, busy13, done13, {cout13, s13}, res13);
      end
      step();
    end
    checks++;
    if (done13 !== 1'b1 || busy13 !== 1'b0 || {cout13, s13} !== e) begin
      errors++;
      $display("FAIL %s done cycle 14: busy=%b done=%b {Cout,S}=%h, required busy=0 done=1 {Cout,S}=%h",
               tag, busy13, done13, {cout13, s13}, e);
    end
    res13 = e;
  endtask

  // Leave the done cycle with start low and confirm the pulse was a single cycle.
  task automatic idle8(input string tag);
    step();
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || {cout8, s8} !== res8) begin
      errors++;
      $display("FAIL %s idle: busy=%b done=%b {Cout,S}=%h, required busy=0 done=0 {Cout,S}=%h",
               tag, busy8, done8, {cout8, s8}, res8);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 1'b0; start1 = 1'b0; start13 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0;
    a13 = '0; b13 = '0; cin13 = 1'b0;
    step();
    step();
    rst = 1'b0;
    res8 = '0; res1 = '0; res13 = '0;
    checks++;
    if ({busy8, done8, cout8, s8} !== 11'd0) begin
      errors++;
      $display("FAIL reset w8: busy=%b done=%b Cout=%b S=%h, required all zero", busy8, done8, cout8, s8);
    end
    checks++;
    if ({busy1, done1, cout1, s1} !== 4'd0) begin
      errors++;
      $display("FAIL reset w1: busy=%b done=%b Cout=%b S=%b, required all zero", busy1, done1, cout1, s1);
    end
    checks++;
    if ({busy13, done13, cout13, s13} !== 16'd0) begin
      errors++;
      $display("FAIL reset w13: busy=%b done=%b Cout=%b S=%h, required all zero", busy13, done13, cout13, s13);
    end
  endtask

  task automatic test_basic();
    op8(8'h5A, 8'h3C, 1'b0, "basic_5a_3c");
    idle8("basic_5a_3c");
  endtask

  task automatic test_carry();
    op8(8'hFF, 8'h01, 1'b0, "carry_ff_01");
    idle8("carry_ff_01");
    op8(8'hFF, 8'hFF, 1'b1, "carry_ff_ff_1");
    idle8("carry_ff_ff_1");
    op8(8'h00, 8'h00, 1'b1, "carry_00_00_1");
    idle8("carry_00_00_1");
  endtask

  // A start pulse with different operands in cycle 4 must not disturb the running sum.
  task automatic test_ignore_busy();
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore cycle 5: busy=%b done=%b, required busy=1 done=0", busy8, done8);
    end
    step(); step(); step(); step();
    checks++;
    if (done8 !== 1'b1 || {cout8, s8} !== 9'h030) begin
      errors++;
      $display("FAIL ignore done cycle 9: done=%b {Cout,S}=%h, required done=1 {Cout,S}=030",
               done8, {cout8, s8});
    end
    res8 = 9'h030;
    idle8("ignore_hold1");
    idle8("ignore_hold2");
  endtask

  // Second start is raised during the first done cycle; op8 also checks 0x30 stays visible.
  task automatic test_back_to_back();
    op8(8'h10, 8'h20, 1'b0, "b2b_first");
    op8(8'h01, 8'h02, 1'b1, "b2b_second");
    idle8("b2b_second");
  endtask

  task automatic test_reset_mid();
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step(); step();
    checks++;
    if (busy8 !== 1'b1 || s8 !== 8'h04) begin
      errors++;
      $display("FAIL rstmid before: busy=%b S=%h, required busy=1 S=04", busy8, s8);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    res8 = '0;
    checks++;
    if ({busy8, done8, cout8, s8} !== 11'd0) begin
      errors++;
      $display("FAIL rstmid after: busy=%b done=%b Cout=%b S=%h, required all zero", busy8, done8, cout8, s8);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0) begin
        errors++;
        $display("FAIL rstmid quiet %0d: busy=%b done=%b, required busy=0 done=0", c, busy8, done8);
      end
    end
    op8(8'h12, 8'h34, 1'b0, "rstmid_next");
    idle8("rstmid_next");
  endtask

  task automatic test_random8();
    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), "rand8");
      if ($urandom_range(0, 1) == 1) idle8("rand8");
    end
    idle8("rand8_end");
  endtask

  task automatic test_width1();
    op1(1'b1, 1'b1, 1'b1, "w1_111");
    step();
    for (int v = 0; v < 8; v++) begin
      logic [2:0] bits;
      bits = 3'(v);
      op1(bits[2], bits[1], bits[0], "w1_all");
    end
    step();
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || {cout1, s1} !== res1) begin
      errors++;
      $display("FAIL w1 idle: busy=%b done=%b {Cout,S}=%b, required busy=0 done=0 {Cout,S}=%b",
               busy1, done1, {cout1, s1}, res1);
    end
  endtask

  task automatic test_width13();
    op13(13'h1FFF, 13'h0001, 1'b0, "w13_wrap");
    op13(13'h1234, 13'h0FED, 1'b1, "w13_mix");
    op13(13'h1FFF, 13'h1FFF, 1'b1, "w13_max");
    for (int i = 0; i < 100; i++) begin
      op13(13'($urandom), 13'($urandom), 1'($urandom_range(0, 1)), "rand13");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random8();
    test_width1();
    test_width13();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial multi-bit adder built around the team's existing 1-bit full-adder cell. The controller latches two WIDTH-bit operands and a carry-in. It then feeds one operand bit pair per clock, LSB first, into a single full-adder instance and registers the carry between cycles. It sits directly upstream of the full-adder cell, driving its A/B/Cin inputs and consuming its S/Cout outputs. It trades latency for area in datapaths where a parallel ripple adder is too large.

Parameters:
WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin an addition; sampled only when busy=0
A  input  WIDTH  operand A; latched on an accepted start
B  input  WIDTH  operand B; latched on an accepted start
Cin  input  1  carry-in; latched on an accepted start
busy  output  1  high while the serial addition is in progress
done  output  1  single-cycle pulse; S/Cout hold a new result
S  output  WIDTH  registered sum; updated only on completion
Cout  output  1  registered carry-out; updated only on completion

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, S=0, Cout=0. Internal shift registers, carry flop and bit counter are also cleared to 0.
- FSM states are IDLE, SHIFT and DONE. The state register is the only sequencing element; busy and done are decoded registered outputs.
- IDLE: if start=1, latch A into a_sh, B into b_sh, Cin into carry, clear count and res_sh, then go to SHIFT. Otherwise stay.
- SHIFT, every cycle:
  - The full-adder cell sees A=a_sh[0], B=b_sh[0], Cin=carry.
  - Right-shift its S into res_sh (new bit enters at MSB).
  - carry <= cell Cout; shift a_sh and b_sh right by 1; count <= count+1.
  - When count = WIDTH-1 on this edge: load S <= final res_sh (including this cycle's bit) and Cout <= cell Cout, then go to DONE.
- DONE: done=1, busy=0 for exactly this one cycle.
  - start=1 here is accepted like IDLE: operands are latched and the next state is SHIFT (back-to-back operation, no idle bubble).
  - Otherwise go to IDLE.
- Latency: start sampled high at the end of cycle 0 -> busy=1 in cycles 1..WIDTH -> done=1 in cycle WIDTH+1, with S/Cout valid from that cycle.
- S and Cout hold their last result through IDLE and through a following SHIFT phase. They change only at a completion edge or on reset.
- start while busy=1 is ignored. Operand, Cin and counter state are unaffected.
- A, B and Cin are don't-care except on the edge a start is accepted. Changes while busy have no effect.
- Reset mid-operation: rst=1 on any edge aborts the operation, with no done pulse. All outputs take their reset values on that edge; S and Cout are cleared even if they held a prior result. rst has priority over start.
- Arithmetic: {Cout,S} = A + B + Cin, unsigned, (WIDTH+1) bits exact; no saturation.
- WIDTH=1: exactly one SHIFT cycle; done in cycle 2.
- Counter width is clog2(WIDTH+1) bits. The counter never wraps within an operation.

Test Plan:
1. WIDTH=8, reset, then start with A=0x5A, B=0x3C, Cin=0 -> busy high for cycles 1-8; done pulse in cycle 9 only; S=0x96, Cout=0.
2. A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1. Then A=0xFF, B=0xFF, Cin=1 -> S=0xFF, Cout=1. Then A=0x00, B=0x00, Cin=1 -> S=0x01, Cout=0.
3. Start with A=0x10, B=0x20, Cin=0. Pulse start with A=0xFF, B=0xFF in cycle 4 -> ignored; done in cycle 9 with S=0x30, Cout=0; S holds 0x30 afterwards.
4. Back-to-back: assert start in the DONE cycle with A=0x01, B=0x02, Cin=1 -> the second done pulse comes exactly 9 cycles later with S=0x04. The first result (previous S) stays visible until that edge.
5. Start A=0xAA, B=0x55; assert rst in cycle 5 -> busy=0, done never pulses, S=0x00, Cout=0. The next start operates normally.
6. Run 1000 random operands and Cin against a reference sum, checking {Cout,S} and the done timing. Repeat with WIDTH=1 (e.g. 1+1+1 -> S=1, Cout=1, done in cycle 2) and WIDTH=13.
